paddle_controller: RTL and testbench

Per-side paddle position generator for the pong game. Produces the `y_pad` vertical paddle position consumed by the ball logic, which in turn publishes `x_ball`/`y_ball` back to this block. The paddle is driven either by two player buttons or, when compiled in and selected, by a computer opponent that tracks the ball. The block sits in the game-logic layer beside the ball logic and advances only on the shared `timing_tick`.

---
 rtl/pong_pkg.sv | 18 +
 rtl/vga_pkg.sv | 6 +
 rtl/paddle_ai_tracker.sv | 122 ++++++++++++
 rtl/paddle_controller.sv | 92 +++++++++
 tb/tb_paddle_controller.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: game-object geometry and the paddle AI state type, shared by the
// paddle controllers and the ball logic.
package pong_pkg;
    import vga_pkg::*;

    localparam int PAD_HEIGHT   = 145;
    localparam int BALL_SIZE    = 15;
    localparam int X_PAD_L      = 20;
    localparam int X_PAD_R      = HOR_PIXELS - 40;
    localparam int Y_PAD_MAX    = VER_PIXELS - PAD_HEIGHT;
    localparam int Y_PAD_CENTER = (VER_PIXELS - PAD_HEIGHT) / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REACT = 2'd1,
        TRACK = 2'd2
    } paddle_ai_state_t;
endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: display geometry shared by the video and game-logic layers.
// Contents: HOR_PIXELS, VER_PIXELS for the 1024x768 raster.
package vga_pkg;
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
endpackage

// File: rtl/paddle_ai_tracker.sv
// paddle_ai_tracker: computer-opponent core. Detects whether the ball is
// approaching this side, delays by REACT_TICKS, then tracks the ball centre.
// Outputs a signed per-tick step; the caller applies it and clamps.
// Ports: clk, rst (sync, active-high), timing_tick, ai_mode, x_ball[10:0],
//        y_ball[9:0], y_pad[9:0] (current paddle top), step[11:0] signed.
//
// state | meaning
// IDLE  | ball receding (or AI off); drift toward the centre position
// REACT | approach seen; paddle frozen while the reaction counter runs down
// TRACK | follow the ball centre outside the dead zone
module paddle_ai_tracker
    import pong_pkg::*;
#(
    parameter int SIDE        = 0,
    parameter int AI_SPEED    = 2,
    parameter int DEAD_ZONE   = 8,
    parameter int REACT_TICKS = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic               ai_mode,
    input  logic [10:0]        x_ball,
    input  logic [9:0]         y_ball,
    input  logic [9:0]         y_pad,
    output logic signed [11:0] step
);
    localparam int CW = (REACT_TICKS > 1) ? $clog2(REACT_TICKS + 1) : 1;
    localparam logic [CW-1:0]     REACT_INIT = CW'(REACT_TICKS);
    localparam logic signed [11:0] AI_SPD    = 12'(AI_SPEED);
    localparam logic signed [11:0] DZ        = 12'(DEAD_ZONE);
    localparam logic signed [11:0] PAD_HALF  = 12'(PAD_HEIGHT / 2);
    localparam logic signed [11:0] BALL_HALF = 12'(BALL_SIZE / 2);
    localparam logic signed [11:0] CENTER_S  = 12'(Y_PAD_CENTER);

    paddle_ai_state_t  state_q, state_d;
    logic [10:0]       x_prev_q, x_prev_d;
    logic              appr_q, appr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rise, fall;
    logic signed [11:0] err, abs_err, diff;

    always_comb begin
        appr_d = appr_q;
        if (x_ball > x_prev_q)
            appr_d = (SIDE == 1);
        else if (x_ball < x_prev_q)
            appr_d = (SIDE == 0);
        rise = appr_d & ~appr_q;
        fall = ~appr_d & appr_q;
        x_prev_d = x_ball;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!ai_mode) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = REACT;
                        cnt_d   = REACT_INIT;
                    end
                end
                REACT: begin
                    if (fall) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q != '0)
                            cnt_d = cnt_q - 1'b1;
                        // Counter reaches zero on this tick: start tracking next.
                        if (cnt_q <= CW'(1))
                            state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (fall)
                        state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        err     = ($signed({2'b00, y_ball}) + BALL_HALF) - ($signed({2'b00, y_pad}) + PAD_HALF);
        abs_err = (err < 0) ? -err : err;
        diff    = '0;
        case (state_q)
            IDLE:    diff = CENTER_S - $signed({2'b00, y_pad});
            TRACK:   diff = (abs_err > DZ) ? err : 12'sd0;
            default: diff = '0;
        endcase
        if (diff > AI_SPD)
            step = AI_SPD;
        else if (diff < -AI_SPD)
            step = -AI_SPD;
        else
            step = diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_prev_q <= '0;
            appr_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (timing_tick) begin
            state_q  <= state_d;
            x_prev_q <= x_prev_d;
            appr_q   <= appr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/paddle_controller.sv
// paddle_controller: per-side paddle position generator. Moves y_pad from the
// player buttons or, when PADDLE_AI_EN is defined and ai_mode=1, from the
// paddle_ai_tracker step. Position is clamped to 0..Y_PAD_MAX.
// Ports: clk, rst (sync, active-high), timing_tick, btn_up, btn_down,
//        ai_mode (PADDLE_AI_EN builds only), x_ball[10:0], y_ball[9:0],
//        y_pad[9:0] (registered paddle top).
// Macro: PADDLE_AI_EN enables the ai_mode port and the AI tracker.
module paddle_controller
    import pong_pkg::*;
#(
    parameter int SIDE        = 0,
    parameter int PAD_SPEED   = 4,
    parameter int AI_SPEED    = 2,
    parameter int DEAD_ZONE   = 8,
    parameter int REACT_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        btn_up,
    input  logic        btn_down,
`ifdef PADDLE_AI_EN
    input  logic        ai_mode,
`endif
    input  logic [10:0] x_ball,
    input  logic [9:0]  y_ball,
    output logic [9:0]  y_pad
);
    localparam logic signed [11:0] PAD_SPD = 12'(PAD_SPEED);
    localparam logic signed [11:0] MAX_S   = 12'(Y_PAD_MAX);
    localparam logic [9:0]         CENTER  = 10'(Y_PAD_CENTER);

    logic [9:0]         y_pad_q, y_pad_d;
    logic signed [11:0] man_step, sel_step, y_sum;

    always_comb begin
        man_step = '0;
        if (btn_up && !btn_down)
            man_step = -PAD_SPD;
        else if (btn_down && !btn_up)
            man_step = PAD_SPD;
    end

`ifdef PADDLE_AI_EN
    logic signed [11:0] ai_step;

    paddle_ai_tracker #(
        .SIDE        (SIDE),
        .AI_SPEED    (AI_SPEED),
        .DEAD_ZONE   (DEAD_ZONE),
        .REACT_TICKS (REACT_TICKS)
    ) u_ai (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .ai_mode     (ai_mode),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .y_pad       (y_pad_q),
        .step        (ai_step)
    );

    assign sel_step = ai_mode ? ai_step : man_step;
`else
    // Ball position only feeds the AI; keep the ports but tie them off here.
    logic unused_ball;
    assign unused_ball = ^{x_ball, y_ball};
    assign sel_step    = man_step;
`endif

    always_comb begin
        y_sum   = $signed({2'b00, y_pad_q}) + sel_step;
        y_pad_d = y_pad_q;
        if (timing_tick) begin
            if (y_sum < 0)
                y_pad_d = '0;
            else if (y_sum > MAX_S)
                y_pad_d = MAX_S[9:0];
            else
                y_pad_d = y_sum[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            y_pad_q <= CENTER;
        else
            y_pad_q <= y_pad_d;
    end

    assign y_pad = y_pad_q;
endmodule

// File: tb/tb_paddle_controller.sv
// tb_paddle_controller: directed bench for paddle_controller (SIDE=1).
// Manual-mode scenarios always run; AI scenarios run when PADDLE_AI_EN is set.
module tb_paddle_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        timing_tick = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
`ifdef PADDLE_AI_EN
    logic        ai_mode = 1'b0;
`endif
    logic [10:0] x_ball = '0;
    logic [9:0]  y_ball = '0;
    logic [9:0]  y_pad;

    int checks = 0;
    int failures = 0;
    int exp_y;

    always #5 clk = ~clk;

    paddle_controller #(
        .SIDE        (1),
        .PAD_SPEED   (4),
        .AI_SPEED    (2),
        .DEAD_ZONE   (8),
        .REACT_TICKS (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
`ifdef PADDLE_AI_EN
        .ai_mode     (ai_mode),
`endif
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .y_pad       (y_pad)
    );

    // Inputs change on the falling edge; results are sampled on the next one.
    task automatic tick();
        timing_tick = 1'b1;
        @(negedge clk);
        timing_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (y_pad !== 10'd311) begin
            failures++;
            $display("FAIL reset: y_pad=%0d expected 311", y_pad);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (y_pad !== 10'd311) begin
                failures++;
                $display("FAIL idle_tick%0d: y_pad=%0d expected 311", i, y_pad);
            end
        end
    endtask

    task automatic test_btn_up();
        btn_up = 1'b1;
        exp_y = 311;
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_y = (exp_y >= 4) ? exp_y - 4 : 0;
            checks++;
            if (y_pad !== 10'(exp_y)) begin
                failures++;
                $display("FAIL btn_up_tick%0d: y_pad=%0d expected %0d", i, y_pad, exp_y);
            end
        end
        btn_up = 1'b0;
    endtask

    // From 0, 155 presses reach 620; the next saturates at 623.
    task automatic test_btn_down();
        btn_down = 1'b1;
        exp_y = 0;
        for (int i = 0; i < 160; i++) begin
            tick();
            exp_y = (exp_y + 4 > 623) ? 623 : exp_y + 4;
            checks++;
            if (y_pad !== 10'(exp_y)) begin
                failures++;
                $display("FAIL btn_down_tick%0d: y_pad=%0d expected %0d", i, y_pad, exp_y);
            end
        end
        btn_down = 1'b0;
    endtask

    task automatic test_both_buttons();
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (y_pad !== 10'd623) begin
                failures++;
                $display("FAIL both_btn_tick%0d: y_pad=%0d expected 623", i, y_pad);
            end
        end
        btn_down = 1'b0;
    endtask

    // btn_up held, no ticks: nothing moves; then one tick moves exactly once.
    task automatic test_no_tick_hold();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (y_pad !== 10'd623) begin
                failures++;
                $display("FAIL no_tick_clk%0d: y_pad=%0d expected 623", i, y_pad);
            end
        end
        tick();
        checks++;
        if (y_pad !== 10'd619) begin
            failures++;
            $display("FAIL first_tick_move: y_pad=%0d expected 619", y_pad);
        end
    endtask

    task automatic test_reset_mid_move();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (y_pad !== 10'd311) begin
            failures++;
            $display("FAIL reset_mid_move: y_pad=%0d expected 311", y_pad);
        end
        btn_up = 1'b0;
        tick();
        checks++;
        if (y_pad !== 10'd311) begin
            failures++;
            $display("FAIL after_reset_tick: y_pad=%0d expected 311", y_pad);
        end
    endtask

`ifdef PADDLE_AI_EN
    int xb;

    // Ball approaches right side, centre at 607: frozen through tick 20,
    // +2 per tick from tick 21, settles at 527 (err=8). Buttons ignored.
    task automatic test_ai_approach();
        ai_mode = 1'b1;
        y_ball = 10'd600;
        xb = 100;
        x_ball = 11'(xb);
        do_reset();
        btn_up = 1'b1;
        exp_y = 311;
        for (int k = 0; k < 140; k++) begin
            x_ball = 11'(xb);
            tick();
            xb += 2;
            if (k > 20 && exp_y < 527)
                exp_y += 2;
            checks++;
            if (y_pad !== 10'(exp_y)) begin
                failures++;
                $display("FAIL ai_approach_tick%0d: y_pad=%0d expected %0d", k, y_pad, exp_y);
            end
        end
        btn_up = 1'b0;
    endtask

    task automatic test_ai_dead_zone();
        logic [9:0] yb_tab [0:2];
        int         ex_tab [0:2];
        yb_tab[0] = 10'd592; ex_tab[0] = 527;  // err 0
        yb_tab[1] = 10'd598; ex_tab[1] = 527;  // err 6
        yb_tab[2] = 10'd602; ex_tab[2] = 529;  // err 10 -> one step, then err 8
        for (int p = 0; p < 3; p++) begin
            y_ball = yb_tab[p];
            for (int i = 0; i < 3; i++) begin
                x_ball = 11'(xb);
                tick();
                xb += 2;
                checks++;
                if (y_pad !== 10'(ex_tab[p])) begin
                    failures++;
                    $display("FAIL ai_dead_zone_p%0d_t%0d: y_pad=%0d expected %0d", p, i, y_pad, ex_tab[p]);
                end
            end
        end
    endtask

    // Reverse (->IDLE, no move at err 8), re-approach (IDLE step -2 while
    // entering REACT), 15 REACT ticks, reverse at counter 5, drift to 311.
    task automatic test_ai_react_abort();
        xb -= 4;
        x_ball = 11'(xb);
        tick();
        checks++;
        if (y_pad !== 10'd529) begin
            failures++;
            $display("FAIL ai_reverse_track: y_pad=%0d expected 529", y_pad);
        end
        xb += 2;
        x_ball = 11'(xb);
        tick();
        checks++;
        if (y_pad !== 10'd527) begin
            failures++;
            $display("FAIL ai_reapproach: y_pad=%0d expected 527", y_pad);
        end
        for (int i = 0; i < 16; i++) begin
            xb = (i < 15) ? xb + 2 : xb - 2;
            x_ball = 11'(xb);
            tick();
            checks++;
            if (y_pad !== 10'd527) begin
                failures++;
                $display("FAIL ai_react_freeze%0d: y_pad=%0d expected 527", i, y_pad);
            end
        end
        exp_y = 527;
        for (int i = 0; i < 115; i++) begin
            xb -= 2;
            x_ball = 11'(xb);
            tick();
            if (exp_y > 311)
                exp_y -= 2;
            checks++;
            if (y_pad !== 10'(exp_y)) begin
                failures++;
                $display("FAIL ai_recentre%0d: y_pad=%0d expected %0d", i, y_pad, exp_y);
            end
        end
    endtask

    task automatic test_ai_mode_switch();
        ai_mode = 1'b0;
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        checks++;
        if (y_pad !== 10'd307) begin
            failures++;
            $display("FAIL mode_switch_manual: y_pad=%0d expected 307", y_pad);
        end
    endtask

    task automatic test_ai_reset_mid_track();
        ai_mode = 1'b1;
        y_ball = 10'd600;
        do_reset();
        xb = 200;
        for (int k = 0; k < 25; k++) begin
            x_ball = 11'(xb);
            tick();
            xb += 2;
        end
        checks++;
        if (y_pad !== 10'd319) begin
            failures++;
            $display("FAIL ai_track_before_reset: y_pad=%0d expected 319", y_pad);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (y_pad !== 10'd311) begin
            failures++;
            $display("FAIL ai_reset_mid_track: y_pad=%0d expected 311", y_pad);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_btn_up();
        test_btn_down();
        test_both_buttons();
        test_no_tick_hold();
        test_reset_mid_move();
`ifdef PADDLE_AI_EN
        test_ai_approach();
        test_ai_dead_zone();
        test_ai_react_abort();
        test_ai_mode_switch();
        test_ai_reset_mid_track();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
